// File: rtl/rosc_meas_ctrl.sv
// rosc_meas_ctrl: sequencer and edge-count meter for a ring-oscillator bank.
// Enables one VCO, waits SETTLE_LEN cycles, then counts RO_IN edges for WIN_LEN cycles.
// Ports: CLK, RST (async, active high), START/STOP control,
//   RO_IDX/SETTLE_LEN/WIN_LEN request fields, RO_IN divided VCO output,
//   EN_VCO one-hot enables, BUSY, VALID pulse, COUNT/OVF/RES_IDX result.
// Optional macro ROSC_SCAN_EN adds input SCAN to sweep all oscillators in order.
module rosc_meas_ctrl #(
  parameter int NUM_RO = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SET_W  = 8,
  localparam int IDX_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [IDX_W-1:0]  RO_IDX,
  input  logic [SET_W-1:0]  SETTLE_LEN,
  input  logic [WIN_W-1:0]  WIN_LEN,
`ifdef ROSC_SCAN_EN
  input  logic              SCAN,
`endif
  input  logic              RO_IN,
  output logic [NUM_RO-1:0] EN_VCO,
  output logic              BUSY,
  output logic              VALID,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF,
  output logic [IDX_W-1:0]  RES_IDX
);

  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_MEAS   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
`ifdef ROSC_SCAN_EN
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RO - 1);
`endif

  localparam logic [IDX_W:0] RO_LIM = (IDX_W + 1)'(NUM_RO);

  logic [2:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic [SET_W-1:0]  set_q, set_src;
  logic [WIN_W-1:0]  win_q;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [TMR_W-1:0]  set_ld, win_ld;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf_q, ovf_nxt;
  logic              sync1, sync2, sync3;
  logic              edge_det;
  logic              scan_in, start_ok, valid_nxt;
  logic [NUM_RO-1:0] en_nxt;

`ifdef ROSC_SCAN_EN
  logic scan_q;
  assign scan_in = SCAN;
`else
  assign scan_in = 1'b0;
`endif

  assign edge_det = sync2 & ~sync3;
  assign BUSY     = (state != ST_IDLE);

  // Out-of-range index is only rejected for single measurements.
  assign start_ok = START & ~STOP
                  & (scan_in | ({1'b0, RO_IDX} < RO_LIM));

  // Timer counts down to zero; a length of 0 behaves like 1.
  assign set_src = (state == ST_IDLE) ? SETTLE_LEN : set_q;
  assign set_ld  = (set_src == '0) ? '0
                 : TMR_W'(set_src) - TMR_W'(1);
  assign win_ld  = (win_q == '0) ? '0
                 : TMR_W'(win_q) - TMR_W'(1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    tmr_nxt   = tmr;
    if (state != ST_IDLE && STOP) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state_nxt = ST_SETTLE;
            idx_nxt   = scan_in ? '0 : RO_IDX;
            tmr_nxt   = set_ld;
          end
        end
        ST_SETTLE: begin
          if (tmr == '0) begin
            state_nxt = ST_MEAS;
            tmr_nxt   = win_ld;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        ST_MEAS: begin
          if (tmr == '0) begin
            state_nxt = ST_DONE;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
`ifdef ROSC_SCAN_EN
          if (scan_q && idx_q != LAST_IDX) begin
            state_nxt = ST_GAP;
            idx_nxt   = idx_q + IDX_W'(1);
          end
`endif
        end
`ifdef ROSC_SCAN_EN
        ST_GAP: begin
          state_nxt = ST_SETTLE;
          tmr_nxt   = set_ld;
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counter is held at zero through SETTLE so MEAS starts clean.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf_q;
    if (state == ST_SETTLE) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (state == ST_MEAS && win_q != '0 && edge_det) begin
      if (cnt == '1) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    en_nxt = '0;
    if (state_nxt == ST_SETTLE || state_nxt == ST_MEAS) begin
      en_nxt[idx_nxt] = 1'b1;
    end
  end

  assign valid_nxt = (state == ST_MEAS) && (state_nxt == ST_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      set_q   <= '0;
      win_q   <= '0;
      tmr     <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      EN_VCO  <= '0;
      VALID   <= 1'b0;
      COUNT   <= '0;
      OVF     <= 1'b0;
      RES_IDX <= '0;
`ifdef ROSC_SCAN_EN
      scan_q  <= 1'b0;
`endif
    end else begin
      sync1  <= RO_IN;
      sync2  <= sync1;
      sync3  <= sync2;
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      tmr    <= tmr_nxt;
      cnt    <= cnt_nxt;
      ovf_q  <= ovf_nxt;
      EN_VCO <= en_nxt;
      VALID  <= valid_nxt;
      if (state == ST_IDLE && start_ok) begin
        set_q  <= SETTLE_LEN;
        win_q  <= WIN_LEN;
`ifdef ROSC_SCAN_EN
        scan_q <= scan_in;
`endif
      end
      // Capture includes any edge seen in the final window cycle.
      if (valid_nxt) begin
        COUNT   <= cnt_nxt;
        OVF     <= ovf_nxt;
        RES_IDX <= idx_q;
      end
    end
  end

endmodule
